// File: rtl/sdram_cmd_sequencer_if.sv
// Host-side access handshake between a requester and sdram_cmd_sequencer.
//   CMD_REQ  : access request, held until CMD_ACK
//   CMD_RD   : 1 = read, 0 = write, stable while CMD_REQ is high
//   CMD_ACK  : one-cycle pulse, access accepted (same cycle as activate)
//   CMD_DONE : one-cycle pulse, closing precharge issued
interface sdram_cmd_sequencer_if;
  logic CMD_REQ;
  logic CMD_RD;
  logic CMD_ACK;
  logic CMD_DONE;

  modport master (output CMD_REQ, CMD_RD, input CMD_ACK, CMD_DONE);
  modport slave  (input CMD_REQ, CMD_RD, output CMD_ACK, CMD_DONE);
endinterface

// File: rtl/sdram_cmd_sequencer.sv
// SDRAM command scheduler. Runs power-up init (NOP wait, precharge, two
// refreshes, load mode), then serves periodic refresh and one host requester.
// Each host access is activate -> read/write -> closing precharge. Refresh
// wins every arbitration point; an accepted access is never preempted.
// Ports:
//   CLK, RESET    : clock, synchronous active-high reset
//   host (slave)  : CMD_REQ/CMD_RD in, CMD_ACK/CMD_DONE out
//   INIT_DONE     : high once init completes
//   REF_OVERRUN   : sticky, refresh period expired with a refresh still pending
//   do_initial    : high throughout init
//   do_precharge, do_refresh, do_load_mode, do_reada, do_writea, do_rw :
//                   one-cycle command strobes, at most one per cycle
//   rw_flag       : direction latched at CMD_ACK
// All outputs are registered.
module sdram_cmd_sequencer #(
  parameter int unsigned INIT_CYCLES = 20000,
  parameter int unsigned REF_PERIOD  = 780,
  parameter int unsigned TRP         = 3,
  parameter int unsigned TRFC        = 8,
  parameter int unsigned TMRD        = 2,
  parameter int unsigned TRCD        = 3,
  parameter int unsigned TBURST      = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  sdram_cmd_sequencer_if.slave  host,
  output logic                  INIT_DONE,
  output logic                  REF_OVERRUN,
  output logic                  do_initial,
  output logic                  do_precharge,
  output logic                  do_refresh,
  output logic                  do_load_mode,
  output logic                  do_reada,
  output logic                  do_writea,
  output logic                  do_rw,
  output logic                  rw_flag
);

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
    S_IDLE, S_REF, S_ACT, S_RW, S_PRE
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_nxt, wait_tgt;
  logic [15:0] ref_cnt;
  logic        ref_pending, ref_hit, ref_req;
  logic        timer_done, arb, issue_ref;
  logic        pre_n, ref_n, lmr_n, rda_n, wra_n, rw_n, ack_n, done_n;
  logic        rwf_n, init_done_n;

  // ref_cnt holds the number of cycles elapsed in the current period, so the
  // expiry is visible to arbitration in the very cycle it happens.
  assign ref_hit = INIT_DONE && (ref_cnt == 16'(REF_PERIOD));
  assign ref_req = ref_pending | ref_hit;

  // wait_cnt counts up from 1 after a command; the next command goes out on
  // the edge where it reaches the state's delay. IDLE has a zero target so it
  // arbitrates every cycle.
  always_comb begin
    wait_tgt = '0;
    case (state)
      S_INIT_WAIT: wait_tgt = 16'(INIT_CYCLES);
      S_INIT_PRE:  wait_tgt = 16'(TRP);
      S_INIT_REF1: wait_tgt = 16'(TRFC);
      S_INIT_REF2: wait_tgt = 16'(TRFC);
      S_INIT_MRS:  wait_tgt = 16'(TMRD);
      S_REF:       wait_tgt = 16'(TRFC);
      S_ACT:       wait_tgt = 16'(TRCD);
      S_RW:        wait_tgt = 16'(TBURST);
      S_PRE:       wait_tgt = 16'(TRP);
      default:     wait_tgt = '0;
    endcase
  end

  assign timer_done = (wait_cnt >= wait_tgt);

  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt + 16'd1;
    pre_n       = 1'b0;
    ref_n       = 1'b0;
    lmr_n       = 1'b0;
    rda_n       = 1'b0;
    wra_n       = 1'b0;
    rw_n        = 1'b0;
    ack_n       = 1'b0;
    done_n      = 1'b0;
    rwf_n       = rw_flag;
    init_done_n = INIT_DONE;
    arb         = 1'b0;
    issue_ref   = 1'b0;

    if (timer_done) begin
      case (state)
        S_INIT_WAIT: begin pre_n = 1'b1; state_nxt = S_INIT_PRE;  wait_nxt = 16'd1; end
        S_INIT_PRE:  begin ref_n = 1'b1; state_nxt = S_INIT_REF1; wait_nxt = 16'd1; end
        S_INIT_REF1: begin ref_n = 1'b1; state_nxt = S_INIT_REF2; wait_nxt = 16'd1; end
        S_INIT_REF2: begin lmr_n = 1'b1; state_nxt = S_INIT_MRS;  wait_nxt = 16'd1; end
        S_INIT_MRS:  begin init_done_n = 1'b1; arb = 1'b1; end
        S_ACT:       begin rw_n = 1'b1; state_nxt = S_RW; wait_nxt = 16'd1; end
        S_RW: begin
          pre_n     = 1'b1;
          done_n    = 1'b1;
          state_nxt = S_PRE;
          wait_nxt  = 16'd1;
        end
        default: arb = 1'b1; // S_IDLE, S_REF, S_PRE
      endcase
    end

    if (arb) begin
      if (ref_req) begin
        ref_n     = 1'b1;
        issue_ref = 1'b1;
        state_nxt = S_REF;
        wait_nxt  = 16'd1;
      end else if (host.CMD_REQ) begin
        rda_n     = host.CMD_RD;
        wra_n     = ~host.CMD_RD;
        ack_n     = 1'b1;
        rwf_n     = host.CMD_RD;
        state_nxt = S_ACT;
        wait_nxt  = 16'd1;
      end else begin
        state_nxt = S_IDLE;
        wait_nxt  = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= S_INIT_WAIT;
      wait_cnt      <= '0;
      ref_cnt       <= '0;
      ref_pending   <= 1'b0;
      REF_OVERRUN   <= 1'b0;
      INIT_DONE     <= 1'b0;
      do_initial    <= 1'b0;
      do_precharge  <= 1'b0;
      do_refresh    <= 1'b0;
      do_load_mode  <= 1'b0;
      do_reada      <= 1'b0;
      do_writea     <= 1'b0;
      do_rw         <= 1'b0;
      rw_flag       <= 1'b0;
      host.CMD_ACK  <= 1'b0;
      host.CMD_DONE <= 1'b0;
    end else begin
      state         <= state_nxt;
      wait_cnt      <= wait_nxt;
      INIT_DONE     <= init_done_n;
      do_initial    <= ~init_done_n;
      do_precharge  <= pre_n;
      do_refresh    <= ref_n;
      do_load_mode  <= lmr_n;
      do_reada      <= rda_n;
      do_writea     <= wra_n;
      do_rw         <= rw_n;
      rw_flag       <= rwf_n;
      host.CMD_ACK  <= ack_n;
      host.CMD_DONE <= done_n;

      // Timer starts on the cycle INIT_DONE rises; that cycle counts as 1.
      if (!INIT_DONE) ref_cnt <= init_done_n ? 16'd1 : 16'd0;
      else            ref_cnt <= ref_hit ? 16'd1 : ref_cnt + 16'd1;

      // A refresh issued on an expiry edge with one already pending serves the
      // old request; the new expiry stays pending.
      if (issue_ref) ref_pending <= ref_pending & ref_hit;
      else           ref_pending <= ref_pending | ref_hit;

      if (ref_hit && ref_pending) REF_OVERRUN <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
module tb_sdram_cmd_sequencer;
  localparam int INIT_CYCLES = 8, TRP = 2, TRFC = 4, TMRD = 2, TRCD = 2, TBURST = 4;
  localparam int REF_PERIOD  = 50;

  localparam logic [7:0] EV_PRE = 8'h80, EV_REF = 8'h40, EV_LMR = 8'h20, EV_RDA = 8'h10;
  localparam logic [7:0] EV_WRA = 8'h08, EV_RW = 8'h04, EV_ACK = 8'h02, EV_DONE = 8'h01;

  typedef struct packed {
    int unsigned cyc;
    logic [7:0]  ev;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic rst_q = 1'b1;
  int   cyc_n = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  sdram_cmd_sequencer_if h1();
  sdram_cmd_sequencer_if h2();

  logic idone1, ovr1, init1, pre1, ref1, lmr1, rda1, wra1, rw1, rwf1;
  logic idone2, ovr2, init2, pre2, ref2, lmr2, rda2, wra2, rw2, rwf2;

  sdram_cmd_sequencer #(
    .INIT_CYCLES(INIT_CYCLES), .REF_PERIOD(REF_PERIOD), .TRP(TRP), .TRFC(TRFC),
    .TMRD(TMRD), .TRCD(TRCD), .TBURST(TBURST)
  ) dut (
    .CLK(CLK), .RESET(RESET), .host(h1.slave), .INIT_DONE(idone1), .REF_OVERRUN(ovr1),
    .do_initial(init1), .do_precharge(pre1), .do_refresh(ref1), .do_load_mode(lmr1),
    .do_reada(rda1), .do_writea(wra1), .do_rw(rw1), .rw_flag(rwf1)
  );

  // Short refresh period so back-to-back accesses starve refresh into overrun.
  sdram_cmd_sequencer #(
    .INIT_CYCLES(INIT_CYCLES), .REF_PERIOD(6), .TRP(TRP), .TRFC(TRFC),
    .TMRD(TMRD), .TRCD(TRCD), .TBURST(TBURST)
  ) dut_ovr (
    .CLK(CLK), .RESET(RESET), .host(h2.slave), .INIT_DONE(idone2), .REF_OVERRUN(ovr2),
    .do_initial(init2), .do_precharge(pre2), .do_refresh(ref2), .do_load_mode(lmr2),
    .do_reada(rda2), .do_writea(wra2), .do_rw(rw2), .rw_flag(rwf2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // cyc_n - 1 at a negedge is the index of the preceding edge.
  always @(posedge CLK) begin
    rst_q <= RESET;
    if (RESET) cyc_n <= 0;
    else       cyc_n <= cyc_n + 1;
  end

  // Scoreboard: every strobe seen on dut must match the head of the queue.
  logic [7:0] mon_ev;
  exp_t       mon_e;
  always @(negedge CLK) begin
    if (!rst_q) begin
      mon_ev = {pre1, ref1, lmr1, rda1, wra1, rw1, h1.CMD_ACK, h1.CMD_DONE};
      if (mon_ev != 8'h00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {24'h0, 32'(cyc_n - 1), mon_ev}, 64'h0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pulse", {24'h0, 32'(cyc_n - 1), mon_ev}, {24'h0, mon_e});
        end
      end
    end
  end

  task automatic push(input int c, input logic [7:0] ev);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    int k = 0;
    while ((cyc_n - 1) < n) begin
      @(negedge CLK);
      k++;
      if (k > 2000) begin
        chk("timeout", 64'(cyc_n - 1), 64'(n));
        return;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {idone1, ovr1, init1, pre1, ref1, lmr1, rda1, wra1, rw1, rwf1,
              h1.CMD_ACK, h1.CMD_DONE,
              idone2, ovr2, init2, pre2, ref2, lmr2, rda2, wra2, rw2, rwf2,
              h2.CMD_ACK, h2.CMD_DONE}, 64'h0);
  endtask

  // Called at a negedge: the next posedge is cycle 0.
  task automatic release_rst();
    RESET = 1'b0;
    push(8, EV_PRE);
    push(10, EV_REF);
    push(14, EV_REF);
    push(18, EV_LMR);
  endtask

  initial begin
    h1.CMD_REQ = 1'b0; h1.CMD_RD = 1'b0;
    h2.CMD_REQ = 1'b0; h2.CMD_RD = 1'b1;
    repeat (3) @(negedge CLK);
    chk_all_zero("reset_outputs");
    release_rst();

    // init sequence
    wait_cyc(0);  chk("do_initial@0", init1, 1'b1); chk("init_done@0", idone1, 1'b0);
    wait_cyc(19); chk("do_initial@19", init1, 1'b1); chk("init_done@19", idone1, 1'b0);
    wait_cyc(20); chk("do_initial@20", init1, 1'b0); chk("init_done@20", idone1, 1'b1);

    // read access, request first sampled at 25
    wait_cyc(24);
    h1.CMD_REQ = 1'b1; h1.CMD_RD = 1'b1;
    push(25, EV_RDA | EV_ACK); push(27, EV_RW); push(31, EV_PRE | EV_DONE);
    wait_cyc(25); chk("rw_flag_rd@25", rwf1, 1'b1); h1.CMD_REQ = 1'b0;

    // write request raised early, must wait for the arbitration point at 33
    wait_cyc(26);
    h1.CMD_REQ = 1'b1; h1.CMD_RD = 1'b0;
    push(33, EV_WRA | EV_ACK); push(35, EV_RW); push(39, EV_PRE | EV_DONE);
    wait_cyc(32); chk("rw_flag_held@32", rwf1, 1'b1);
    wait_cyc(33); chk("rw_flag_wr@33", rwf1, 1'b0); h1.CMD_REQ = 1'b0;

    // refresh expiry at 70 collides with a request
    wait_cyc(69);
    h1.CMD_REQ = 1'b1; h1.CMD_RD = 1'b1;
    push(70, EV_REF); push(74, EV_RDA | EV_ACK); push(76, EV_RW); push(80, EV_PRE | EV_DONE);
    wait_cyc(74); chk("rw_flag_rd@74", rwf1, 1'b1); h1.CMD_REQ = 1'b0;
    push(120, EV_REF);
    wait_cyc(120); chk("no_overrun_idle", ovr2, 1'b0); chk("no_overrun_main", ovr1, 1'b0);

    // access abandoned by reset after do_rw
    wait_cyc(124);
    h1.CMD_REQ = 1'b1; h1.CMD_RD = 1'b0;
    push(125, EV_WRA | EV_ACK); push(127, EV_RW);
    wait_cyc(125); h1.CMD_REQ = 1'b0;
    wait_cyc(127); RESET = 1'b1;
    @(negedge CLK); chk_all_zero("midaccess_reset");
    @(negedge CLK); chk_all_zero("reset_hold");
    chk("queue_drained_at_reset", 64'(exp_q.size()), 64'h0);

    // second run: dut re-inits; dut_ovr sees back-to-back accesses
    h2.CMD_REQ = 1'b1;
    release_rst();
    wait_cyc(0);  chk("reinit_do_initial@0", init1, 1'b1);
    wait_cyc(20); chk("reinit_done@20", idone1, 1'b1); chk("ovr_clear@20", ovr2, 1'b0);
    wait_cyc(60); chk("overrun_set", ovr2, 1'b1);
    wait_cyc(66); chk("overrun_sticky", ovr2, 1'b1); chk("main_no_overrun", ovr1, 1'b0);
    chk("queue_empty", 64'(exp_q.size()), 64'h0);

    RESET = 1'b1;
    @(negedge CLK); chk("overrun_cleared", ovr2, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
